// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 transmitter byte interface among NUM_REQ
// requesters. Round-robin grant, held for a burst until the holder marks its
// last byte, sends MAX_BURST bytes, or stays idle for IDLE_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_BURST    = 16,
  parameter  int IDLE_TIMEOUT = 64,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_data_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_data_ready,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id
);

  // Counter widths cover the terminal value; a disabled limit keeps a 1-bit stub.
  localparam int BCNT_W = (MAX_BURST    > 0) ? $clog2(MAX_BURST + 1)    : 1;
  localparam int ICNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'((MAX_BURST    > 0) ? MAX_BURST - 1    : 0);
  localparam logic [ICNT_W-1:0] IDLE_LAST  = ICNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                    state_q;
  logic [ID_W-1:0]           grant_id_q;
  logic [ID_W-1:0]           ptr_q;
  logic [BCNT_W-1:0]         byte_cnt_q;
  logic [ICNT_W-1:0]         idle_cnt_q;

  logic [NUM_REQ-1:0][7:0]   req_bytes;
  logic                      pick_found;
  logic [ID_W-1:0]           pick_id;
  logic [ID_W:0]             cand;
  logic                      hold_valid;
  logic                      xfer;
  logic                      release_now;
  logic [ID_W-1:0]           ptr_next;

  assign req_bytes   = req_data;
  assign grant_valid = (state_q == GRANTED);
  assign grant_id    = grant_id_q;

  // Holder's byte is passed straight through; nothing leaks out while idle.
  assign hold_valid    = grant_valid && req_valid[grant_id_q];
  assign tx_data_valid = hold_valid;
  assign tx_data       = hold_valid ? req_bytes[grant_id_q] : 8'h00;
  assign xfer          = hold_valid && tx_data_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign req_ready[i] = grant_valid && (grant_id_q == ID_W'(i)) && tx_data_ready;
  end

  // Any release condition ends the burst; coincident conditions are one release.
  assign release_now = (xfer && req_last[grant_id_q])
                    || ((MAX_BURST != 0) && xfer && (byte_cnt_q == BURST_LAST))
                    || ((IDLE_TIMEOUT != 0) && grant_valid && !req_valid[grant_id_q]
                        && (idle_cnt_q == IDLE_LAST));

  assign ptr_next = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  // Round-robin search: first valid requester at or after the pointer, with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!pick_found && req_valid[cand[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = cand[ID_W-1:0];
      end
    end
  end

  // Grant FSM with saturating burst and idle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      ptr_q      <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q    <= GRANTED;
            grant_id_q <= pick_id;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
          end
        end
        GRANTED: begin
          if (xfer && (byte_cnt_q != '1)) byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
          if (req_valid[grant_id_q])      idle_cnt_q <= '0;
          else if (idle_cnt_q != '1)      idle_cnt_q <= idle_cnt_q + ICNT_W'(1);
          if (release_now) begin
            state_q <= IDLE;
            ptr_q   <= ptr_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=16, IDLE_TIMEOUT=64).
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_data_valid;
  logic [7:0]  tx_data;
  logic        tx_data_ready = 1'b1;
  logic        grant_valid;
  logic [1:0]  grant_id;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(16), .IDLE_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data_valid(tx_data_valid),
    .tx_data(tx_data), .tx_data_ready(tx_data_ready), .grant_valid(grant_valid),
    .grant_id(grant_id)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({grant_valid, tx_data_valid, req_ready, tx_data} !== 14'd0) begin
      n_fail++; $display("FAIL reset_outputs: got gv=%b tdv=%b rdy=%b txd=%h, want all 0", grant_valid, tx_data_valid, req_ready, tx_data);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    req_valid[1] = 1'b1; req_data[15:8] = 8'h3C;
    tick();
    @(negedge clk);
    n_chk++;
    if ({grant_valid, grant_id, tx_data_valid, tx_data} !== {1'b1, 2'd1, 1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL reset_burst_start: got gv=%b id=%0d tdv=%b txd=%h, want 1 1 1 3c", grant_valid, grant_id, tx_data_valid, tx_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({grant_valid, tx_data_valid, req_ready, tx_data} !== 14'd0) begin
      n_fail++; $display("FAIL reset_async_midburst: got gv=%b tdv=%b rdy=%b txd=%h, want all 0", grant_valid, tx_data_valid, req_ready, tx_data);
    end
    req_valid = '0;
    tick(); tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++;
      if (grant_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_grant: cycle %0d got gv=%b want 0", k, grant_valid);
      end
    end
  endtask

  task automatic test_single();
    tick();
    req_valid = 4'b0100; req_data[23:16] = 8'h55; req_last = '0;
    @(negedge clk);
    n_chk++;
    if (grant_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got gv=%b want 0", grant_valid);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if ({grant_valid, grant_id, tx_data_valid, tx_data, req_ready} !== {1'b1, 2'd2, 1'b1, 8'h55, 4'b0100}) begin
      n_fail++; $display("FAIL single_byte0: got gv=%b id=%0d tdv=%b txd=%h rdy=%b, want 1 2 1 55 0100", grant_valid, grant_id, tx_data_valid, tx_data, req_ready);
    end
    tick();
    req_data[23:16] = 8'hA3; req_last[2] = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({grant_valid, grant_id, tx_data, req_ready} !== {1'b1, 2'd2, 8'hA3, 4'b0100}) begin
      n_fail++; $display("FAIL single_byte1: got gv=%b id=%0d txd=%h rdy=%b, want 1 2 a3 0100", grant_valid, grant_id, tx_data, req_ready);
    end
    tick();
    req_valid = '0; req_last = '0;
    @(negedge clk);
    n_chk++;
    if (grant_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_release: got gv=%b want 0", grant_valid);
    end
    // pointer now 3: with req 2 and 3 both valid, 3 must win
    tick();
    req_valid = 4'b1100; req_data[23:16] = 8'h66; req_data[31:24] = 8'h77; req_last = 4'b1100;
    tick();
    @(negedge clk);
    n_chk++;
    if ({grant_valid, grant_id, tx_data} !== {1'b1, 2'd3, 8'h77}) begin
      n_fail++; $display("FAIL single_pointer: got gv=%b id=%0d txd=%h, want 1 3 77", grant_valid, grant_id, tx_data);
    end
    tick();
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_round_robin();
    logic [1:0] rr_exp [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
    logic [1:0] eid;
    logic [7:0] eb;
    tick();
    req_valid = 4'b1011; req_last = 4'b1111;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_chk++;
      if (k % 2 == 1) begin
        eid = rr_exp[k/2];
        eb  = 8'h10 + {6'd0, eid};
        if ({grant_valid, grant_id, tx_data} !== {1'b1, eid, eb}) begin
          n_fail++; $display("FAIL rr_grant: cycle %0d got gv=%b id=%0d txd=%h, want 1 %0d %h", k, grant_valid, grant_id, tx_data, eid, eb);
        end
      end else if (grant_valid !== 1'b0) begin
        n_fail++; $display("FAIL rr_gap: cycle %0d got gv=%b want 0", k, grant_valid);
      end
      tick();
    end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_burst_cap();
    int n1 = 0;
    bit done0 = 1'b0;
    bit egv;
    logic [1:0] eid;
    logic [7:0] eb;
    for (int k = 0; k < 25; k++) begin
      tick();
      req_valid[1] = (n1 < 20); req_data[15:8] = 8'h80 + 8'(n1); req_last[1] = (n1 == 19);
      req_valid[0] = !done0;    req_data[7:0]  = 8'h5A;           req_last[0] = 1'b1;
      @(negedge clk);
      egv = (k >= 1 && k <= 16) || (k == 18) || (k >= 20 && k <= 23);
      eid = (k == 18) ? 2'd0 : 2'd1;
      eb  = (k == 18) ? 8'h5A : 8'h80 + 8'(n1);
      n_chk++;
      if (egv) begin
        if ({grant_valid, grant_id, tx_data} !== {1'b1, eid, eb}) begin
          n_fail++; $display("FAIL burst_grant: cycle %0d got gv=%b id=%0d txd=%h, want 1 %0d %h", k, grant_valid, grant_id, tx_data, eid, eb);
        end
        if (eid == 2'd1) n1++; else done0 = 1'b1;
      end else if (grant_valid !== 1'b0) begin
        n_fail++; $display("FAIL burst_gap: cycle %0d got gv=%b want 0", k, grant_valid);
      end
    end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_timeout();
    bit egv, etdv;
    logic [1:0] eid;
    logic [7:0] eb;
    // move the pointer to 0 with a one-byte burst from req 3
    tick();
    req_valid = 4'b1000; req_data[31:24] = 8'h99; req_last = 4'b1000;
    tick(); tick();
    req_valid = '0; req_last = '0;
    for (int k = 0; k < 132; k++) begin
      tick();
      req_valid[0] = (k <= 1) || (k == 64); req_data[7:0] = (k < 64) ? 8'h11 : 8'h22; req_last[0] = 1'b0;
      req_valid[2] = (k <= 130);            req_data[23:16] = 8'h33;                 req_last[2] = 1'b1;
      @(negedge clk);
      egv  = (k >= 1 && k <= 128) || (k == 130);
      eid  = (k == 130) ? 2'd2 : 2'd0;
      etdv = (k == 1) || (k == 64) || (k == 130);
      eb   = (k == 1) ? 8'h11 : (k == 64) ? 8'h22 : (k == 130) ? 8'h33 : 8'h00;
      n_chk++;
      if (grant_valid !== egv || (egv && grant_id !== eid) || tx_data_valid !== etdv || tx_data !== eb) begin
        n_fail++; $display("FAIL timeout: cycle %0d got gv=%b id=%0d tdv=%b txd=%h, want %b %0d %b %h", k, grant_valid, grant_id, tx_data_valid, tx_data, egv, eid, etdv, eb);
      end
    end
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_backpressure();
    tick();
    tx_data_ready = 1'b0;
    req_valid = 4'b1000; req_data[31:24] = 8'hC7; req_last = 4'b1000;
    for (int k = 1; k <= 160; k++) begin
      tick();
      @(negedge clk);
      n_chk++;
      if ({grant_valid, grant_id, tx_data_valid, tx_data, req_ready} !== {1'b1, 2'd3, 1'b1, 8'hC7, 4'b0000}) begin
        n_fail++; $display("FAIL bp_hold: cycle %0d got gv=%b id=%0d tdv=%b txd=%h rdy=%b, want 1 3 1 c7 0000", k, grant_valid, grant_id, tx_data_valid, tx_data, req_ready);
      end
    end
    tick();
    tx_data_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({tx_data_valid, tx_data, req_ready} !== {1'b1, 8'hC7, 4'b1000}) begin
      n_fail++; $display("FAIL bp_ready: got tdv=%b txd=%h rdy=%b, want 1 c7 1000", tx_data_valid, tx_data, req_ready);
    end
    tick();
    req_valid = '0; req_last = '0;
    @(negedge clk);
    n_chk++;
    if (grant_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got gv=%b want 0", grant_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_timeout();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
